hack_seq: RTL and testbench

Multi-cycle instruction sequencer for the Hack CPU. It owns the program counter and fetches instructions from instruction ROM over a req/ack handshake. It decodes A- and C-instructions into single-cycle register write strobes and applies the jump decision from the jump-control block to update the PC. It sits between instruction ROM, the A/D/M register write enables and the jump evaluator.

---
 rtl/hack_seq.sv | 122 ++++++++++++
 tb/tb_hack_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hack_seq.sv
// Hack CPU instruction sequencer: PC ownership, ROM fetch over req/ack, A/C decode to write strobes.
// Optional HALT state is built when HACK_SEQ_HALT_EN is defined.
module hack_seq #(
  parameter int              PC_W      = 15,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            rom_req,
  output logic [PC_W-1:0] rom_addr,
  input  logic            rom_ack,
  input  logic [15:0]     rom_data,
  output logic [15:0]     instr,
  output logic            is_c,
  output logic            a_load,
  output logic            d_load,
  output logic            m_write,
  input  logic            pc_load,
  input  logic            pc_inc,
  input  logic [15:0]     a_reg,
  input  logic            halt,
  output logic            halted,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     retired,
  output logic            seq_err
);

`ifdef HACK_SEQ_HALT_EN
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_EXEC} state_t;
`endif

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic [15:0]     retired_q, retired_d;
  logic            seq_err_q, seq_err_d;
  // Keeps rom_req low while rst is held and until the first edge after release.
  logic            req_en_q, req_en_d;

  logic unused_in;
`ifdef HACK_SEQ_HALT_EN
  assign unused_in = ^a_reg;
`else
  assign unused_in = ^{a_reg, halt};
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    seq_err_d = seq_err_q;
    req_en_d  = 1'b1;
    rom_req   = req_en_q && (state_q == S_FETCH);
    a_load    = 1'b0;
    d_load    = 1'b0;
    m_write   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (rom_req && rom_ack) begin
          instr_d = rom_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        a_load    = instr_q[15] ? instr_q[5] : 1'b1;
        d_load    = instr_q[15] & instr_q[4];
        m_write   = instr_q[15] & instr_q[3];
        // Jump target is the A value before this instruction's own A write lands.
        pc_d      = (instr_q[15] && pc_load) ? a_reg[PC_W-1:0] : pc_q + PC_W'(1);
        retired_d = retired_q + 16'd1;
        if (instr_q[15] && (pc_load == pc_inc))
          seq_err_d = 1'b1;
        state_d   = S_FETCH;
`ifdef HACK_SEQ_HALT_EN
        if (halt)
          state_d = S_HALT;
`endif
      end
`ifdef HACK_SEQ_HALT_EN
      S_HALT: begin
        if (!halt)
          state_d = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_VEC;
      instr_q   <= '0;
      retired_q <= '0;
      seq_err_q <= 1'b0;
      req_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      seq_err_q <= seq_err_d;
      req_en_q  <= req_en_d;
    end
  end

  assign rom_addr = pc_q;
  assign pc       = pc_q;
  assign instr    = instr_q;
  assign is_c     = instr_q[15];
  assign retired  = retired_q;
  assign seq_err  = seq_err_q;
`ifdef HACK_SEQ_HALT_EN
  assign halted   = (state_q == S_HALT);
`else
  assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_hack_seq.sv
// Directed bench for hack_seq: fetch/exec timing, jumps, strobes, PC wrap, seq_err, reset abort, halt.
module tb_hack_seq;
  localparam int PC_W = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rom_req, rom_ack;
  logic [PC_W-1:0] rom_addr, pc;
  logic [15:0]     rom_data, instr, a_reg, retired;
  logic            is_c, a_load, d_load, m_write, pc_load, pc_inc, halt, halted, seq_err;
  logic [15:0]     rom [0:63];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr[5:0]];

  hack_seq #(.PC_W(PC_W), .RESET_VEC('0)) dut (
    .clk(clk), .rst(rst), .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
    .rom_data(rom_data), .instr(instr), .is_c(is_c), .a_load(a_load), .d_load(d_load),
    .m_write(m_write), .pc_load(pc_load), .pc_inc(pc_inc), .a_reg(a_reg), .halt(halt),
    .halted(halted), .pc(pc), .retired(retired), .seq_err(seq_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Entered at a negedge in FETCH; leaves at the negedge of the EXEC cycle.
  task automatic fetch(input int waits, input logic [PC_W-1:0] addr);
    rom_ack = 1'b0;
    for (int i = 0; i < waits; i++) begin
      step();
      check("wait_req", rom_req, 1'b1);
      check("wait_addr", rom_addr, addr);
      check("wait_no_strobe", {a_load, d_load, m_write}, 3'b000);
    end
    rom_ack = 1'b1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    rom[0]  = 16'h0005;
    rom[1]  = 16'hEA87;
    rom[2]  = 16'h0003;
    rom[16] = 16'hEA87;
    rom[17] = 16'hFC98;
    rom[18] = 16'h0007;
    rom[19] = 16'hEA87;
    rom[32] = 16'hEA87;
    rom[63] = 16'hEA80;
    rom_ack = 1'b0; pc_load = 1'b0; pc_inc = 1'b1; a_reg = 16'h0000; halt = 1'b0;

    step(); step();
    check("rst_req", rom_req, 1'b0);
    check("rst_pc", pc, 0);
    check("rst_instr", instr, 0);
    check("rst_strobes", {a_load, d_load, m_write}, 3'b000);
    check("rst_cnt_err_halt", {retired, seq_err, halted}, 18'h0);

    rst = 1'b0;
    step();
    check("req_after_rst", rom_req, 1'b1);
    check("addr_after_rst", rom_addr, 0);

    // 1: A-instr 0x0005, immediate ack
    fetch(0, 0);
    check("a_instr_aload", {a_load, d_load, m_write, is_c}, 4'b1000);
    check("a_instr_latch", instr, 16'h0005);
    step();
    check("a_instr_pc", pc, 1);
    check("a_instr_ret", retired, 1);
    check("a_instr_strobe_drop", a_load, 1'b0);

    // 2: 0;JMP taken to 0x10
    a_reg = 16'h0010; pc_load = 1'b1; pc_inc = 1'b0;
    fetch(0, 1);
    check("jmp_is_c", is_c, 1'b1);
    check("jmp_strobes", {a_load, d_load, m_write}, 3'b000);
    step();
    check("jmp_pc", pc, 16'h10);

    // 3: same jump not taken
    pc_load = 1'b0; pc_inc = 1'b1;
    fetch(0, 16); step();
    check("nojmp_pc", pc, 16'h11);
    check("nojmp_ret", retired, 3);

    // 4: D and M strobes
    fetch(0, 17);
    check("dm_strobes", {a_load, d_load, m_write}, 3'b011);
    step();
    check("dm_pc", pc, 16'h12);

    // 5: three wait states, EXEC on fifth cycle after FETCH entry
    fetch(3, 18);
    check("wait_exec_aload", a_load, 1'b1);
    step();
    check("wait_pc", pc, 16'h13);

    // 6: jump to 0x7FFF, 7: non-jump wraps to 0
    a_reg = 16'h7FFF; pc_load = 1'b1; pc_inc = 1'b0;
    fetch(0, 19); step();
    check("jmp_top_pc", pc, 16'h7FFF);
    pc_load = 1'b0; pc_inc = 1'b1;
    fetch(0, 15'h7FFF); step();
    check("wrap_pc", pc, 0);

    // 8: A-instr ignores pc_load and does not flag seq_err
    pc_load = 1'b1; pc_inc = 1'b1; a_reg = 16'h0020;
    fetch(0, 0); step();
    check("a_ignore_jmp_pc", pc, 1);
    check("a_no_err", seq_err, 1'b0);

    // 9: C-instr with pc_load==pc_inc flags error, still jumps
    fetch(0, 1);
    check("err_exec_clear", seq_err, 1'b0);
    step();
    check("err_set", seq_err, 1'b1);
    check("err_pc", pc, 16'h20);

    // 10: jump to 7, error stays sticky
    a_reg = 16'h0007; pc_load = 1'b1; pc_inc = 1'b0;
    fetch(0, 32); step();
    check("err_sticky", seq_err, 1'b1);
    check("pc7", pc, 7);
    check("ret10", retired, 10);

    // Reset while waiting in FETCH at pc=7
    rom_ack = 1'b0; pc_load = 1'b0; pc_inc = 1'b1;
    step();
    #2 rst = 1'b1;
    #1;
    check("midfetch_req", rom_req, 1'b0);
    check("midfetch_pc", pc, 0);
    check("midfetch_strobes", {a_load, d_load, m_write}, 3'b000);
    check("midfetch_err_ret", {seq_err, retired}, 17'h0);
    step(); rst = 1'b0; step();
    check("refetch_addr", {rom_req, rom_addr}, {1'b1, 15'h0});

    // Reset during EXEC aborts the strobe
    fetch(0, 0);
    check("midexec_aload_pre", a_load, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midexec_aload", a_load, 1'b0);
    check("midexec_pc_ret", {pc, retired}, 31'h0);
    step(); rst = 1'b0; step();

    // Halt after instruction at pc=2
    fetch(0, 0); step();
    pc_load = 1'b0; pc_inc = 1'b1;
    fetch(0, 1); step();
    check("pre_halt_pc", pc, 2);
    fetch(0, 2);
    halt = 1'b1;
    rom_ack = 1'b0;
    step();
    check("halt_pc", pc, 3);
    check("halt_strobes", {a_load, d_load, m_write}, 3'b000);
`ifdef HACK_SEQ_HALT_EN
    check("halted", halted, 1'b1);
    check("halt_req", rom_req, 1'b0);
    step();
    check("halt_hold", {halted, rom_req}, 2'b10);
`else
    check("halted_off", halted, 1'b0);
    check("halt_req_off", rom_req, 1'b1);
    step();
    check("halt_hold_off", {halted, rom_req}, 2'b01);
`endif
    halt = 1'b0;
    step();
    check("resume", {halted, rom_req, rom_addr}, {2'b01, 15'd3});
    check("resume_pc", pc, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1);
  end
endmodule
